// File: rtl/mac_operand_feeder_if.sv
// MAC-side bus between mac_operand_feeder (master) and mac_unit (slave).
interface mac_operand_feeder_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
);
  logic                     mac_clr;
  logic                     mac_enable;
  logic signed [DATA_W-1:0] mac_a;
  logic signed [DATA_W-1:0] mac_b;
  logic signed [ACC_W-1:0]  mac_acc;

  modport master (output mac_clr, mac_enable, mac_a, mac_b, input  mac_acc);
  modport slave  (input  mac_clr, mac_enable, mac_a, mac_b, output mac_acc);
endinterface

// File: rtl/mac_operand_feeder.sv
// Operand sequencer for mac_unit: buffers one A-row/B-column, streams len pairs, captures the dot product.
// Optional macro MAC_FEEDER_STALL_EN adds a stall input that pauses streaming.
module mac_operand_feeder #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]          len,
  input  logic                     start,
`ifdef MAC_FEEDER_STALL_EN
  input  logic                     stall,
`endif
  output logic                     busy,
  output logic                     done,
  output logic signed [ACC_W-1:0]  result,
  mac_operand_feeder_if.master     mac
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CLEAR   = 2'd1;
  localparam logic [1:0] S_STREAM  = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [ADDR_W:0]          len_q, len_d;
  logic [ADDR_W:0]          idx_q, idx_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     clr_q, clr_d;
  logic                     en_q, en_d;
  logic signed [DATA_W-1:0] a_q, a_d;
  logic signed [DATA_W-1:0] b_q, b_d;
  logic signed [ACC_W-1:0]  result_q, result_d;

  logic signed [DATA_W-1:0] buf_a [DEPTH];
  logic signed [DATA_W-1:0] buf_b [DEPTH];

  logic            stall_w;
  logic            wr_ok;
  logic [ADDR_W:0] len_sat;

`ifdef MAC_FEEDER_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  assign wr_ok   = int'(wr_addr) < DEPTH;
  assign len_sat = (int'(len) > DEPTH) ? (ADDR_W+1)'(DEPTH) : len;

  // NOTE: operand buffers carry no reset; stale contents are never read before being written by the loader.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      if (wr_sel) buf_b[wr_addr] <= wr_data;
      else        buf_a[wr_addr] <= wr_data;
    end
  end

  // NOTE: every next-state signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    clr_d    = 1'b0;
    en_d     = 1'b0;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len_sat;
          idx_d   = '0;
          busy_d  = 1'b1;
          clr_d   = 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (len_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          en_d    = 1'b1;
          a_d     = buf_a[0];
          b_d     = buf_b[0];
          idx_d   = (ADDR_W+1)'(1);
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        // A stall holds index and operands with enable low, so no pair is consumed.
        if (!stall_w) begin
          if (idx_q == len_q) begin
            a_d     = '0;
            b_d     = '0;
            state_d = S_CAPTURE;
          end else begin
            en_d  = 1'b1;
            a_d   = buf_a[idx_q[ADDR_W-1:0]];
            b_d   = buf_b[idx_q[ADDR_W-1:0]];
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        result_d = mac.mac_acc;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        idx_d    = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      clr_q    <= 1'b0;
      en_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      clr_q    <= clr_d;
      en_q     <= en_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign result         = result_q;
  assign mac.mac_clr    = clr_q;
  assign mac.mac_enable = en_q;
  assign mac.mac_a      = a_q;
  assign mac.mac_b      = b_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Self-checking bench for mac_operand_feeder: behavioural MAC, shadow buffers, table vectors and random runs.
module tb_mac_operand_feeder;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset, wr_en, wr_sel, start;
  logic [ADDR_W-1:0]        wr_addr;
  logic signed [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]          len;
  logic                     busy, done;
  logic signed [ACC_W-1:0]  result;
`ifdef MAC_FEEDER_STALL_EN
  logic                     stall;
`endif

  mac_operand_feeder_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) mif();

  mac_operand_feeder #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .len     (len),
    .start   (start),
`ifdef MAC_FEEDER_STALL_EN
    .stall   (stall),
`endif
    .busy    (busy),
    .done    (done),
    .result  (result),
    .mac     (mif)
  );

  // Behavioural mac_unit: clear wins, otherwise accumulate on enable, wrapping at ACC_W bits.
  logic signed [ACC_W-1:0] acc_m = '0;
  always @(posedge clk) begin
    if (mif.mac_clr)         acc_m <= '0;
    else if (mif.mac_enable) acc_m <= acc_m + 32'(longint'(mif.mac_a) * longint'(mif.mac_b));
  end
  assign mif.mac_acc = acc_m;

  int tests = 0;
  int fails = 0;
  int sh_a [DEPTH];
  int sh_b [DEPTH];

  typedef struct packed {
    logic [0:3][7:0]    a;
    logic [0:3][7:0]    b;
    logic [5:0]         len;
    logic signed [31:0] exp_result;
    int                 exp_done;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input bit sel, input int addr, input int data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = addr[ADDR_W-1:0];
    wr_data = data[DATA_W-1:0];
    @(posedge clk);
    #1 wr_en = 1'b0;
    if (addr < DEPTH) begin
      if (sel) sh_b[addr] = data;
      else     sh_a[addr] = data;
    end
  endtask

  function automatic int model_dot(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += sh_a[i] * sh_b[i];
    return s;
  endfunction

  function automatic int sat_len(input int l);
    return (l > DEPTH) ? DEPTH : l;
  endfunction

  // One run from start to done; k counts clock edges after E0, sampled at the following negedge.
  task automatic run(input string tag, input int len_in, input bit poke, input int stall_at,
                     input int stall_n, input int exp_res, input int exp_done);
    int n = sat_len(len_in);
    int en_cnt = 0;
    int bad_pairs = 0;
    int done_at = -1;
`ifdef MAC_FEEDER_STALL_EN
    logic signed [DATA_W-1:0] held_a = '0;
`endif
    @(negedge clk);
    len   = len_in[ADDR_W:0];
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        check({tag, "_clr_pulse"}, mif.mac_clr, 1);
        check({tag, "_busy"}, busy, 1);
      end
      if (k == 1) check({tag, "_clr_off"}, mif.mac_clr, 0);
      if (poke) start = (k == 3 || k == 4);
`ifdef MAC_FEEDER_STALL_EN
      stall = (stall_n > 0 && k >= stall_at && k < stall_at + stall_n);
      if (stall_n > 0 && k == stall_at) held_a = mif.mac_a;
      if (stall_n > 0 && k > stall_at && k <= stall_at + stall_n) begin
        check({tag, "_stall_hold_a"}, mif.mac_a, held_a);
        check({tag, "_stall_no_en"}, mif.mac_enable, 0);
      end
`endif
      if (mif.mac_enable) begin
        if (en_cnt >= DEPTH || mif.mac_a != sh_a[en_cnt] || mif.mac_b != sh_b[en_cnt]) bad_pairs++;
        en_cnt++;
      end
      if (done) begin
        done_at = k;
        break;
      end
    end
    start = 1'b0;
`ifdef MAC_FEEDER_STALL_EN
    stall = 1'b0;
`endif
    check({tag, "_done_cycle"}, done_at, exp_done);
    check({tag, "_enable_cycles"}, en_cnt, n);
    check({tag, "_pair_order_errs"}, bad_pairs, 0);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_a_zeroed"}, mif.mac_a, 0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_busy_after"}, busy, 0);
    @(negedge clk);
    check({tag, "_no_queued_start"}, busy, 0);
    check({tag, "_result_hold"}, result, exp_res);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs [5];

  initial begin
    // Table entries list operands in index order 0..3.
    vecs[0] = '{a: {-8'sd5, 8'sd1, 8'sd5, 8'sd2},      b: {8'sd5, 8'sd3, 8'sd4, 8'sd6},
                len: 6'd4, exp_result: 32'sd10,     exp_done: 6};
    vecs[1] = '{a: {-8'sd128, 8'sd0, 8'sd0, 8'sd0},    b: {-8'sd128, 8'sd0, 8'sd0, 8'sd0},
                len: 6'd1, exp_result: 32'sd16384,  exp_done: 3};
    vecs[2] = '{a: {8'sd127, 8'sd3, 8'sd3, 8'sd3},     b: {-8'sd128, 8'sd3, 8'sd3, 8'sd3},
                len: 6'd1, exp_result: -32'sd16256, exp_done: 3};
    vecs[3] = '{a: {8'sd9, 8'sd9, 8'sd9, 8'sd9},       b: {8'sd9, 8'sd9, 8'sd9, 8'sd9},
                len: 6'd0, exp_result: 32'sd0,      exp_done: 2};
    vecs[4] = '{a: {-8'sd1, -8'sd1, 8'sd50, 8'sd50},   b: {8'sd1, 8'sd1, 8'sd50, 8'sd50},
                len: 6'd2, exp_result: -32'sd2,     exp_done: 4};

    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_sel  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    len     = '0;
    start   = 1'b0;
`ifdef MAC_FEEDER_STALL_EN
    stall   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_mac_clr", mif.mac_clr, 0);
    check("rst_mac_enable", mif.mac_enable, 0);
    check("rst_mac_a", mif.mac_a, 0);
    check("rst_mac_b", mif.mac_b, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      wr(1'b0, i, int'($urandom_range(0, 255)) - 128);
      wr(1'b1, i, int'($urandom_range(0, 255)) - 128);
    end

    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < 4; j++) begin
        wr(1'b0, j, int'($signed(vecs[v].a[j])));
        wr(1'b1, j, int'($signed(vecs[v].b[j])));
      end
      run($sformatf("vec%0d", v), int'(vecs[v].len), 1'b0, 0, 0,
          int'(vecs[v].exp_result), vecs[v].exp_done);
    end

    // Over-length request with a start pulse while busy.
    for (int i = 0; i < DEPTH; i++) begin
      wr(1'b0, i, int'($urandom_range(0, 255)) - 128);
      wr(1'b1, i, int'($urandom_range(0, 255)) - 128);
    end
    run("len20_poke", 20, 1'b1, 0, 0, model_dot(DEPTH), DEPTH + 2);

    // Reset during the third STREAM cycle, then a clean rerun.
    for (int j = 0; j < 4; j++) begin
      wr(1'b0, j, int'($signed(vecs[0].a[j])));
      wr(1'b1, j, int'($signed(vecs[0].b[j])));
    end
    begin
      bit seen_done = 1'b0;
      @(negedge clk);
      len   = 5'd4;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_streaming", mif.mac_enable, 1);
      reset = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_enable", mif.mac_enable, 0);
      check("abort_done", done, 0);
      check("abort_result", result, 0);
      check("abort_mac_a", mif.mac_a, 0);
      repeat (3) begin
        @(negedge clk);
        seen_done |= done;
      end
      reset = 1'b1;
      repeat (4) begin
        @(negedge clk);
        seen_done |= done;
      end
      check("abort_no_done_pulse", seen_done, 0);
    end
    run("after_abort", 4, 1'b0, 0, 0, 10, 6);

`ifdef MAC_FEEDER_STALL_EN
    run("stall", 4, 1'b0, 2, 2, 10, 8);
`endif

    for (int r = 0; r < 25; r++) begin
      int l;
      int nw = int'($urandom_range(0, 6));
      for (int w = 0; w < nw; w++)
        wr(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
           int'($urandom_range(0, 255)) - 128);
      l = (r == 0) ? DEPTH : int'($urandom_range(0, 31));
      run($sformatf("rnd%0d", r), l, 1'b0, 0, 0, model_dot(sat_len(l)), sat_len(l) + 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
